sram_access_ctrl: RTL and testbench
===================================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk, and reset, which is synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- width, 512, data bits per SRAM row.
- logDepth, 9, SRAM address bits.
- wordsize, 64, bits per write-enable lane.
- latency, 1, cycles from SRAM readAddr sample to valid readData (= SRAM delay+1), minimum 1.
- rspDepth, latency+2, response FIFO entries, minimum latency+2.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when high together with req_valid.
- req_write, in, 1, 1 = write, 0 = read.
- req_addr, in, logDepth, row address.
- req_wdata, in, width, write data.
- req_wmask, in, width/wordsize, per-lane write enable.
- rsp_valid, out, 1, read data available.
- rsp_ready, in, 1, consumer takes data.
- rsp_data, out, width, read data.
- sram_readAddr, out, logDepth, to SRAM readAddr.
- sram_readData, in, width, from SRAM readData.
- sram_writeAddr, out, logDepth, to SRAM writeAddr.
- sram_writeData, out, width, to SRAM writeData.
- sram_writeEnable, out, width/wordsize, to SRAM writeEnable.

Function
REQ-004 A request SHALL be accepted in a cycle only when req_valid and req_ready are both high; at most one request is accepted per cycle.
REQ-005 sram_writeAddr, sram_writeData and sram_readAddr SHALL be combinational copies of req_addr, req_wdata and req_addr.
REQ-006 sram_writeEnable SHALL equal req_wmask in a cycle with an accepted write, and zero in every other cycle.
REQ-007 An accepted write SHALL produce no response; a write with req_wmask=0 is legal and SHALL be accepted as a no-op.
REQ-008 Every accepted read SHALL enter a valid pipeline of length latency; sram_readData SHALL be captured into the response FIFO at the end of cycle c+latency, where c is the acceptance cycle.
REQ-009 The block SHALL keep a credit counter equal to the reads accepted minus the responses popped; its width SHALL be clog2(rspDepth+1).
REQ-010 req_ready SHALL be high when reset is low and either the credit counter is below rspDepth or req_write is high.
REQ-011 req_ready SHALL depend only on registered state, reset and req_write; there SHALL be no combinational path from rsp_ready or rsp_valid to req_ready.
REQ-012 Writes SHALL never be blocked by response backpressure.
REQ-013 The response FIFO SHALL be first-in first-out.
REQ-014 rsp_valid SHALL be high when the FIFO is non-empty, and rsp_data SHALL be the head entry.
REQ-015 A pop SHALL occur when rsp_valid and rsp_ready are both high.
REQ-016 rsp_data SHALL be held stable while rsp_valid is high and rsp_ready is low.
REQ-017 The credit counter SHALL handle a read accept and a pop in the same cycle with a net change of zero.
REQ-018 The FIFO SHALL handle a push and a pop in the same cycle without loss; this is required when full or empty.
REQ-019 FIFO pointers SHALL wrap modulo rspDepth; rspDepth need not be a power of two.
REQ-020 Response order SHALL equal read acceptance order.
REQ-021 With rsp_ready held high, back-to-back reads SHALL sustain one read per cycle, with first data at rsp_valid in cycle c+latency+1.
REQ-022 A write followed by a read of the same address in the next cycle SHALL return the written data; a read in the same cycle as the write returns the prior contents.
REQ-023 The FIFO SHALL never overflow; the credit rule of REQ-010 guarantees this, and the block SHALL include an assertion that checks it.

Reset
REQ-024 While reset is high, req_ready SHALL be 0, rsp_valid SHALL be 0 and sram_writeEnable SHALL be 0.
REQ-025 While reset is high, requests SHALL be ignored.
REQ-026 At the reset edge, the credit counter, the pipeline valids and the FIFO pointers and count SHALL clear to zero.
REQ-027 Reset asserted with reads in flight SHALL discard those reads; no response from them SHALL appear after reset.
REQ-028 In the first cycle after reset deasserts, req_ready SHALL be 1.

Verification
REQ-029 The bench SHALL cover these scenarios (latency=2, width=512, wordsize=64):
- Write addr 5, data all-0xA5, mask 0xFF; read addr 5 next cycle -> rsp_valid in read cycle+3, data all-0xA5.
- Write addr 5, mask 0x01, data lane0=0x1234; read addr 5 -> lane0=0x1234, lanes1-7 unchanged 0xA5.
- 16 back-to-back reads, rsp_ready=1 -> req_ready never drops, 16 responses in order, one per cycle.
- rsp_ready=0, issue reads -> exactly rspDepth=4 accepted, then req_ready=0; writes still accepted; raising rsp_ready for one cycle -> one further read accepted next cycle.
- FIFO full while a pop and a capture occur in the same cycle -> no loss, order preserved, count unchanged.
- Reset asserted with 2 reads in flight and 1 response queued -> rsp_valid=0 during reset and after release; no stale responses; req_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// SRAM access controller: a single request port fans out to a dual-port SRAM.
// Reads flow through a fixed-latency valid pipeline into a response FIFO.
// A credit counter reserves FIFO space at accept time, so the FIFO cannot
// overflow and req_ready never depends combinationally on the response side.
module sram_access_ctrl #(
    parameter int width    = 512,
    parameter int logDepth = 9,
    parameter int wordsize = 64,
    parameter int latency  = 1,
    parameter int rspDepth = latency + 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [logDepth-1:0]          req_addr,
    input  logic [width-1:0]             req_wdata,
    input  logic [width/wordsize-1:0]    req_wmask,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [width-1:0]             rsp_data,
    output logic [logDepth-1:0]          sram_readAddr,
    input  logic [width-1:0]             sram_readData,
    output logic [logDepth-1:0]          sram_writeAddr,
    output logic [width-1:0]             sram_writeData,
    output logic [width/wordsize-1:0]    sram_writeEnable
);

    localparam int lanes = width / wordsize;
    localparam int ptrW  = (rspDepth > 1) ? $clog2(rspDepth) : 1;
    localparam int cntW  = $clog2(rspDepth + 1);

    logic                 reqAccept;
    logic                 readAccept;
    logic                 writeAccept;
    logic                 capture;
    logic                 pop;
    logic [cntW-1:0]      creditReg;
    logic [cntW-1:0]      countReg;
    logic [ptrW-1:0]      wrPtrReg;
    logic [ptrW-1:0]      rdPtrReg;
    logic [latency-1:0]   validPipe;
    logic [latency-1:0]   pipeIn;
    logic [width-1:0]     fifoMem [rspDepth];

    // Credit covers both in-flight reads and queued responses, so a read may
    // only be taken when a FIFO slot is guaranteed; writes never need one.
    assign req_ready   = !reset && ((creditReg < cntW'(rspDepth)) || req_write);
    assign reqAccept   = req_valid && req_ready;
    assign readAccept  = reqAccept && !req_write;
    assign writeAccept = reqAccept && req_write;

    assign sram_readAddr    = req_addr;
    assign sram_writeAddr   = req_addr;
    assign sram_writeData   = req_wdata;
    assign sram_writeEnable = writeAccept ? req_wmask : {lanes{1'b0}};

    assign rsp_valid = !reset && (countReg != '0);
    assign rsp_data  = fifoMem[rdPtrReg];
    assign pop       = rsp_valid && rsp_ready;
    assign capture   = validPipe[latency-1];

    // Pipeline input wiring: stage 0 takes the accepted read, later stages shift.
    for (genvar gi = 0; gi < latency; gi++) begin : g_pipe
        if (gi == 0) begin : g_first
            assign pipeIn[gi] = readAccept;
        end else begin : g_next
            assign pipeIn[gi] = validPipe[gi-1];
        end
    end

    // Valid pipeline: the last stage marks the cycle sram_readData is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            validPipe <= '0;
        end else begin
            validPipe <= pipeIn;
        end
    end

    // Credit counter: +1 per accepted read, -1 per pop, net zero when both.
    always_ff @(posedge clk) begin
        if (reset) begin
            creditReg <= '0;
        end else begin
            case ({readAccept, pop})
                2'b10:   creditReg <= creditReg + cntW'(1);
                2'b01:   creditReg <= creditReg - cntW'(1);
                default: creditReg <= creditReg;
            endcase
        end
    end

    // FIFO storage write; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifoMem[wrPtrReg] <= sram_readData;
        end
    end

    // FIFO pointers and occupancy; pointers wrap at rspDepth (any depth).
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (capture) begin
                wrPtrReg <= (wrPtrReg == ptrW'(rspDepth - 1)) ? '0 : wrPtrReg + ptrW'(1);
            end
            if (pop) begin
                rdPtrReg <= (rdPtrReg == ptrW'(rspDepth - 1)) ? '0 : rdPtrReg + ptrW'(1);
            end
            case ({capture, pop})
                2'b10:   countReg <= countReg + cntW'(1);
                2'b01:   countReg <= countReg - cntW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // Safety net: the credit scheme must keep pushes out of a full FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(capture && !pop && countReg == cntW'(rspDepth)));
            assert (creditReg <= cntW'(rspDepth));
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural SRAM (latency 2).
module tb_sram_access_ctrl;

    localparam int W     = 512;
    localparam int LD    = 9;
    localparam int WS    = 64;
    localparam int LAT   = 2;
    localparam int LANES = W / WS;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [LD-1:0]    req_addr;
    logic [W-1:0]     req_wdata;
    logic [LANES-1:0] req_wmask;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [LD-1:0]    sram_readAddr;
    logic [W-1:0]     sram_readData;
    logic [LD-1:0]    sram_writeAddr;
    logic [W-1:0]     sram_writeData;
    logic [LANES-1:0] sram_writeEnable;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_access_ctrl #(
        .width(W), .logDepth(LD), .wordsize(WS), .latency(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sram_readAddr(sram_readAddr), .sram_readData(sram_readData),
        .sram_writeAddr(sram_writeAddr), .sram_writeData(sram_writeData),
        .sram_writeEnable(sram_writeEnable)
    );

    // SRAM model: one registered read stage plus one delay stage, lane writes.
    logic [W-1:0] mem [1 << LD];
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    always @(posedge clk) begin
        rd1 <= mem[sram_readAddr];
        rd2 <= rd1;
        for (int l = 0; l < LANES; l++) begin
            if (sram_writeEnable[l]) begin
                mem[sram_writeAddr][l*WS +: WS] <= sram_writeData[l*WS +: WS];
            end
        end
    end
    assign sram_readData = rd2;

    function automatic logic [W-1:0] pat(int a);
        return {64{8'(a)}};
    endfunction

    task automatic chk1(string tag, logic obs, logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkV(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of request/response inputs at the falling edge.
    task automatic drive(int v, int w, int a, logic [W-1:0] d, logic [LANES-1:0] m, int rr);
        @(negedge clk);
        req_valid = 1'(v);
        req_write = 1'(w);
        req_addr  = LD'(a);
        req_wdata = d;
        req_wmask = m;
        rsp_ready = 1'(rr);
        #1;
        $display("[TB] t=%0t valid=%0d write=%0d addr=%0d rsp_ready=%0d -> ready=%b rsp_valid=%b",
                 $time, v, w, a, rr, req_ready, rsp_valid);
    endtask

    // One directed cycle with its expected ready/valid/data/write-enable.
    task automatic step(string tag, int v, int w, int a, int rr,
                        int eReady, int eValid, int eAddr, int eWe);
        drive(v, w, a, (w != 0) ? pat(a) : '0, (w != 0) ? 8'hFF : 8'h00, rr);
        chk1({tag, ".ready"}, req_ready, 1'(eReady));
        chk1({tag, ".rspValid"}, rsp_valid, 1'(eValid));
        if (eAddr >= 0) chkV({tag, ".rspData"}, rsp_data, pat(eAddr));
        chkV({tag, ".we"}, W'(sram_writeEnable), W'(eWe));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;

        // Reset: requests present but ignored.
        drive(1, 1, 7, pat(7), 8'hFF, 1);
        chk1("rst.ready", req_ready, 1'b0);
        chk1("rst.rspValid", rsp_valid, 1'b0);
        chkV("rst.we", W'(sram_writeEnable), '0);
        drive(1, 0, 7, '0, '0, 1);
        chk1("rst.readReady", req_ready, 1'b0);
        drive(0, 0, 0, '0, '0, 1);
        reset = 1'b0;
        #1;
        chk1("rel.ready", req_ready, 1'b1);
        chk1("rel.rspValid", rsp_valid, 1'b0);

        // Full-row write then read next cycle.
        drive(1, 1, 5, {64{8'hA5}}, 8'hFF, 1);
        chk1("s1.wready", req_ready, 1'b1);
        chkV("s1.we", W'(sram_writeEnable), W'(8'hFF));
        chkV("s1.waddr", W'(sram_writeAddr), W'(9'd5));
        chkV("s1.wdata", sram_writeData, {64{8'hA5}});
        drive(1, 0, 5, '0, '0, 1);
        chk1("s1.rready", req_ready, 1'b1);
        chkV("s1.rwe", W'(sram_writeEnable), '0);
        chkV("s1.raddr", W'(sram_readAddr), W'(9'd5));
        drive(0, 0, 0, '0, '0, 1);
        chk1("s1.lat1", rsp_valid, 1'b0);
        drive(0, 0, 0, '0, '0, 1);
        chk1("s1.lat2", rsp_valid, 1'b0);
        drive(0, 0, 0, '0, '0, 1);
        chk1("s1.rspValid", rsp_valid, 1'b1);
        chkV("s1.rspData", rsp_data, {64{8'hA5}});
        drive(0, 0, 0, '0, '0, 1);
        chk1("s1.drained", rsp_valid, 1'b0);

        // Single-lane masked write; other lanes keep 0xA5.
        drive(1, 1, 5, {{56{8'hFF}}, 64'h1234}, 8'h01, 1);
        chkV("s2.we", W'(sram_writeEnable), W'(8'h01));
        drive(1, 0, 5, '0, '0, 1);
        drive(0, 0, 0, '0, '0, 1);
        drive(0, 0, 0, '0, '0, 1);
        drive(0, 0, 0, '0, '0, 1);
        chk1("s2.rspValid", rsp_valid, 1'b1);
        chkV("s2.rspData", rsp_data, {{56{8'hA5}}, 64'h1234});
        drive(0, 0, 0, '0, '0, 1);
        chk1("s2.drained", rsp_valid, 1'b0);

        // Preload rows 16..31, then 16 back-to-back reads with rsp_ready high.
        for (int a = 16; a < 32; a++) drive(1, 1, a, pat(a), 8'hFF, 1);
        for (int k = 0; k < 19; k++) begin
            if (k < 16) drive(1, 0, 16 + k, '0, '0, 1);
            else        drive(0, 0, 0, '0, '0, 1);
            if (k < 16) chk1($sformatf("b2b%0d.ready", k), req_ready, 1'b1);
            if (k >= 3) begin
                chk1($sformatf("b2b%0d.rspValid", k), rsp_valid, 1'b1);
                chkV($sformatf("b2b%0d.rspData", k), rsp_data, pat(16 + k - 3));
            end else begin
                chk1($sformatf("b2b%0d.rspValid", k), rsp_valid, 1'b0);
            end
        end
        drive(0, 0, 0, '0, '0, 1);
        chk1("b2b.drained", rsp_valid, 1'b0);

        // Backpressure: four reads fill the credits, writes still pass,
        // one pop frees exactly one read.
        step("bp0", 1, 0, 20, 0, 1, 0, -1, 0);
        step("bp1", 1, 0, 21, 0, 1, 0, -1, 0);
        step("bp2", 1, 0, 22, 0, 1, 0, -1, 0);
        step("bp3", 1, 0, 23, 0, 1, 1, 20, 0);
        step("bp4", 1, 0, 24, 0, 0, 1, 20, 0);
        step("bp5", 1, 0, 24, 0, 0, 1, 20, 0);
        step("bp6", 1, 1, 40, 0, 1, 1, 20, 8'hFF);
        step("bp7", 1, 0, 24, 1, 0, 1, 20, 0);
        step("bp8", 1, 0, 24, 0, 1, 1, 21, 0);
        step("bp9", 1, 0, 25, 0, 0, 1, 21, 0);
        // Credits exhausted; pop and capture coincide, then steady accept+pop.
        step("ff10", 1, 0, 26, 1, 0, 1, 21, 0);
        step("ff11", 1, 0, 26, 1, 1, 1, 22, 0);
        step("ff12", 1, 0, 27, 1, 1, 1, 23, 0);
        step("ff13", 1, 0, 28, 1, 1, 1, 24, 0);
        step("ff14", 0, 0, 0, 1, 1, 1, 26, 0);
        step("ff15", 0, 0, 0, 1, 1, 1, 27, 0);
        step("ff16", 0, 0, 0, 1, 1, 1, 28, 0);
        step("ff17", 0, 0, 0, 1, 1, 0, -1, 0);

        // Reset with two reads in flight and one response queued.
        step("rs0", 1, 0, 16, 0, 1, 0, -1, 0);
        step("rs1", 1, 0, 17, 0, 1, 0, -1, 0);
        step("rs2", 1, 0, 18, 0, 1, 0, -1, 0);
        drive(1, 0, 19, '0, '0, 0);
        reset = 1'b1;
        #1;
        chk1("rs.duringReady", req_ready, 1'b0);
        chk1("rs.duringValid", rsp_valid, 1'b0);
        drive(0, 0, 0, '0, '0, 1);
        reset = 1'b0;
        #1;
        chk1("rs.firstReady", req_ready, 1'b1);
        chk1("rs.firstValid", rsp_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, '0, '0, 1);
            chk1($sformatf("rs.stale%0d", k), rsp_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
